// File: rtl/keyboard_buffer.sv
// -----------------------------------------------------------------------------
// keyboard_buffer
// Turns keyboard press/release events into the CPU's keyboard memory-map word.
//   BUFFERED = 0 (live):   out shows the currently held key, 0 when none.
//   BUFFERED = 1 (queued): presses are queued in a DEPTH-entry FIFO; out shows
//                          the oldest queued code and rd_en consumes it.
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   key_valid    key event present this cycle
//   key_ready    block accepts the event this cycle
//   key_code     key code of the event (WIDTH bits)
//   key_release  1 = release event, 0 = press event
//   rd_en        consume current out value (queued mode only)
//   clr_ovf      clear the sticky overflow flag
//   out          keyboard word, 0 = no key (WIDTH bits)
//   count        entries queued, always 0 in live mode
//   overflow     sticky: a nonzero press was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module keyboard_buffer #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter bit BUFFERED = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     key_valid,
   output logic                     key_ready,
   input  logic [WIDTH-1:0]         key_code,
   input  logic                     key_release,
   input  logic                     rd_en,
   input  logic                     clr_ovf,
   output logic [WIDTH-1:0]         out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

   state_t            state_r;
   logic [WIDTH-1:0]  held_r;
   logic [WIDTH-1:0]  mem_r [DEPTH];
   logic [PW-1:0]     wr_ptr_r;
   logic [PW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic              ready_r;
   logic [WIDTH-1:0]  out_r;
   logic              overflow_r;

   logic              accept_s;
   logic              press_s;
   logic              push_s;
   logic              pop_s;
   logic              ovf_set_s;
   logic [PW-1:0]     rd_next_s;
   logic [CW-1:0]     count_next_s;
   logic [WIDTH-1:0]  head_next_s;
   state_t            state_next_s;
   logic [WIDTH-1:0]  held_next_s;

   assign key_ready = ready_r;
   assign out       = out_r;
   assign count     = count_r;
   assign overflow  = overflow_r;

   // Next-state decode shared by both modes; mode gating is done with BUFFERED.
   always_comb begin
      accept_s  = key_valid & ready_r;
      // Zero-code presses are accepted but treated as no event at all.
      press_s   = accept_s & ~key_release & (key_code != {WIDTH{1'b0}});
      push_s    = BUFFERED & press_s;
      pop_s     = BUFFERED & rd_en & (count_r != {CW{1'b0}});
      ovf_set_s = BUFFERED & key_valid & ~ready_r & ~key_release &
                  (key_code != {WIDTH{1'b0}});

      if (pop_s) begin
         rd_next_s = rd_ptr_r + PW'(1);
      end else begin
         rd_next_s = rd_ptr_r;
      end

      if (push_s && !pop_s) begin
         count_next_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CW'(1);
      end else begin
         count_next_s = count_r;
      end

      // The next head may be the entry being written this very edge (FIFO
      // empty, or one entry being popped while another is pushed), so
      // forward key_code instead of reading stale storage.
      if (push_s && (wr_ptr_r == rd_next_s)) begin
         head_next_s = key_code;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end

      state_next_s = state_r;
      held_next_s  = held_r;
      if (press_s) begin
         state_next_s = HELD;
         held_next_s  = key_code;
      end else if (accept_s && key_release && (state_r == HELD) &&
                   (key_code == held_r)) begin
         state_next_s = IDLE;
      end else begin
         state_next_s = state_r;
      end
   end

   // Control state: live-mode FSM or queued-mode pointers/count, plus outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         held_r     <= {WIDTH{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         ready_r    <= 1'b1;
         out_r      <= {WIDTH{1'b0}};
         overflow_r <= 1'b0;
      end else if (!BUFFERED) begin
         state_r    <= state_next_s;
         held_r     <= held_next_s;
         ready_r    <= 1'b1;
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
         out_r      <= (state_next_s == HELD) ? held_next_s : {WIDTH{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         rd_ptr_r <= rd_next_s;
         count_r  <= count_next_s;
         // Ready is a registered view of "not full" for the coming cycle, so a
         // pop at full frees the slot without raising ready in that same cycle.
         ready_r  <= (count_next_s != FULL);
         out_r    <= (count_next_s != {CW{1'b0}}) ? head_next_s : {WIDTH{1'b0}};
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else if (clr_ovf) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
      end
   end

   // FIFO storage; deliberately not reset, out is masked to 0 while empty.
   always_ff @(posedge clk) begin
      if (rst_n && push_s) begin
         mem_r[wr_ptr_r] <= key_code;
      end
   end

endmodule

// File: tb/tb_keyboard_buffer.sv
module tb_keyboard_buffer;

   logic        clk = 1'b0;
   logic        rst_n;

   // live-mode instance stimulus / observation
   logic        l_valid, l_release, l_rd, l_clr;
   logic [15:0] l_code;
   logic        l_ready, l_ovf;
   logic [15:0] l_out;
   logic [3:0]  l_count;

   // queued-mode instance stimulus / observation
   logic        q_valid, q_release, q_rd, q_clr;
   logic [15:0] q_code;
   logic        q_ready, q_ovf;
   logic [15:0] q_out;
   logic [3:0]  q_count;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [15:0] qm[$];
   bit          qm_ovf;
   bit          lm_on;
   logic [15:0] lm_held;

   always #5 clk = ~clk;

   keyboard_buffer #(.WIDTH(16), .DEPTH(8), .BUFFERED(1'b0)) dut_live (
      .clk(clk), .rst_n(rst_n), .key_valid(l_valid), .key_ready(l_ready),
      .key_code(l_code), .key_release(l_release), .rd_en(l_rd), .clr_ovf(l_clr),
      .out(l_out), .count(l_count), .overflow(l_ovf));

   keyboard_buffer #(.WIDTH(16), .DEPTH(8), .BUFFERED(1'b1)) dut_q (
      .clk(clk), .rst_n(rst_n), .key_valid(q_valid), .key_ready(q_ready),
      .key_code(q_code), .key_release(q_release), .rd_en(q_rd), .clr_ovf(q_clr),
      .out(q_out), .count(q_count), .overflow(q_ovf));

   task automatic idle_inputs();
      l_valid = 1'b0; l_release = 1'b0; l_rd = 1'b0; l_clr = 1'b0; l_code = 16'd0;
      q_valid = 1'b0; q_release = 1'b0; q_rd = 1'b0; q_clr = 1'b0; q_code = 16'd0;
   endtask

   // One clock edge: the model absorbs the same inputs the DUTs sample.
   task automatic tick();
      bit q_rdy;
      bit set;
      @(posedge clk);
      q_rdy = (qm.size() != 8);
      if (!rst_n) begin
         qm.delete(); qm_ovf = 1'b0; lm_on = 1'b0; lm_held = 16'd0;
      end else begin
         if (l_valid && !l_release && l_code != 16'd0) begin
            lm_held = l_code; lm_on = 1'b1;
         end else if (l_valid && l_release && lm_on && l_code == lm_held) begin
            lm_on = 1'b0;
         end
         if (q_rd && qm.size() > 0) void'(qm.pop_front());
         set = q_valid && !q_rdy && !q_release && q_code != 16'd0;
         if (q_valid && q_rdy && !q_release && q_code != 16'd0) qm.push_back(q_code);
         if (set) qm_ovf = 1'b1;
         else if (q_clr) qm_ovf = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      // events during reset must be ignored
      idle_inputs();
      rst_n = 1'b0;
      l_valid = 1'b1; l_code = 16'd33;
      q_valid = 1'b1; q_code = 16'd44; q_clr = 1'b1;
      tick();
      rst_n = 1'b1;
      idle_inputs();
      tests++; if (l_out !== 16'd0) begin fails++; $display("FAIL reset_live_out: got %0d expected 0", l_out); end
      tests++; if (l_ready !== 1'b1) begin fails++; $display("FAIL reset_live_ready: got %0b expected 1", l_ready); end
      tests++; if (q_out !== 16'd0 || q_count !== 4'd0 || q_ovf !== 1'b0) begin
         fails++; $display("FAIL reset_q_state: got out=%0d count=%0d ovf=%0b expected 0/0/0", q_out, q_count, q_ovf); end
      tests++; if (q_ready !== 1'b1) begin fails++; $display("FAIL reset_q_ready: got %0b expected 1", q_ready); end
   endtask

   task automatic test_live();
      do_reset();
      l_valid = 1'b1; l_code = 16'd65; tick();
      idle_inputs();
      tests++; if (l_out !== 16'd65) begin fails++; $display("FAIL live_press: got %0d expected 65", l_out); end
      l_rd = 1'b1; l_clr = 1'b1; tick(); idle_inputs();
      tests++; if (l_out !== 16'd65) begin fails++; $display("FAIL live_hold: got %0d expected 65", l_out); end
      l_valid = 1'b1; l_release = 1'b1; l_code = 16'd65; tick(); idle_inputs();
      tests++; if (l_out !== 16'd0) begin fails++; $display("FAIL live_release: got %0d expected 0", l_out); end
      l_valid = 1'b1; l_code = 16'd65; tick();
      l_code = 16'd66; tick();
      tests++; if (l_out !== 16'd66) begin fails++; $display("FAIL live_replace: got %0d expected 66", l_out); end
      l_release = 1'b1; l_code = 16'd65; tick();
      tests++; if (l_out !== 16'd66) begin fails++; $display("FAIL live_stale_release: got %0d expected 66", l_out); end
      l_release = 1'b0; l_code = 16'd0; tick();
      tests++; if (l_out !== 16'd66) begin fails++; $display("FAIL live_zero_press: got %0d expected 66", l_out); end
      l_release = 1'b1; l_code = 16'd66; tick(); idle_inputs();
      tests++; if (l_out !== 16'd0 || l_count !== 4'd0 || l_ovf !== 1'b0) begin
         fails++; $display("FAIL live_release_new: got out=%0d count=%0d ovf=%0b expected 0/0/0", l_out, l_count, l_ovf); end
   endtask

   task automatic test_queued();
      do_reset();
      q_valid = 1'b1;
      q_code = 16'd65; tick();
      q_code = 16'd66; tick();
      q_release = 1'b1; q_code = 16'd66; tick();   // release discarded
      q_release = 1'b0; q_code = 16'd67; tick();
      idle_inputs();
      tests++; if (q_count !== 4'd3 || q_out !== 16'd65) begin
         fails++; $display("FAIL q_push3: got count=%0d out=%0d expected 3/65", q_count, q_out); end
      q_rd = 1'b1; tick(); idle_inputs();
      tests++; if (q_count !== 4'd2 || q_out !== 16'd66) begin
         fails++; $display("FAIL q_read1: got count=%0d out=%0d expected 2/66", q_count, q_out); end
      q_rd = 1'b1; tick(); tick(); idle_inputs();
      tests++; if (q_count !== 4'd0 || q_out !== 16'd0) begin
         fails++; $display("FAIL q_drain: got count=%0d out=%0d expected 0/0", q_count, q_out); end
      // pointers now sit at 3, so filling to 8 wraps them
      for (int i = 1; i <= 8; i++) begin
         q_valid = 1'b1; q_code = 16'(i); tick();
      end
      idle_inputs();
      tests++; if (q_ready !== 1'b0 || q_count !== 4'd8) begin
         fails++; $display("FAIL q_full: got ready=%0b count=%0d expected 0/8", q_ready, q_count); end
      q_valid = 1'b1; q_code = 16'd9; tick(); idle_inputs();
      tests++; if (q_ovf !== 1'b1 || q_count !== 4'd8 || q_out !== 16'd1) begin
         fails++; $display("FAIL q_overflow: got ovf=%0b count=%0d out=%0d expected 1/8/1", q_ovf, q_count, q_out); end
      q_clr = 1'b1; tick(); idle_inputs();
      tests++; if (q_ovf !== 1'b0) begin fails++; $display("FAIL q_clr_ovf: got %0b expected 0", q_ovf); end
      for (int i = 1; i <= 8; i++) begin
         tests++; if (q_out !== 16'(i)) begin fails++; $display("FAIL q_order: got %0d expected %0d", q_out, i); end
         q_rd = 1'b1; tick();
      end
      idle_inputs();
      tests++; if (q_count !== 4'd0 || q_out !== 16'd0) begin
         fails++; $display("FAIL q_wrap_empty: got count=%0d out=%0d expected 0/0", q_count, q_out); end
      q_valid = 1'b1; q_code = 16'd69; tick();
      q_code = 16'd70; q_rd = 1'b1; tick(); idle_inputs();
      tests++; if (q_count !== 4'd1 || q_out !== 16'd70) begin
         fails++; $display("FAIL q_push_pop: got count=%0d out=%0d expected 1/70", q_count, q_out); end
      q_rd = 1'b1; tick(); tick(); idle_inputs();
      tests++; if (q_count !== 4'd0 || q_out !== 16'd0) begin
         fails++; $display("FAIL q_read_empty: got count=%0d out=%0d expected 0/0", q_count, q_out); end
      // pop at full while a press arrives: press dropped, slot freed
      for (int i = 0; i < 8; i++) begin q_valid = 1'b1; q_code = 16'(100 + i); tick(); end
      q_code = 16'd200; q_rd = 1'b1; tick(); idle_inputs();
      tests++; if (q_count !== 4'd7 || q_ovf !== 1'b1 || q_ready !== 1'b1 || q_out !== 16'd101) begin
         fails++; $display("FAIL q_pop_at_full: got count=%0d ovf=%0b ready=%0b out=%0d expected 7/1/1/101",
                           q_count, q_ovf, q_ready, q_out); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) begin q_valid = 1'b1; q_code = 16'(10 + i); tick(); end
      l_valid = 1'b1; l_code = 16'd77; tick();
      idle_inputs();
      rst_n = 1'b0; q_valid = 1'b1; q_code = 16'd55; l_valid = 1'b1; l_code = 16'd88; tick();
      rst_n = 1'b1; idle_inputs();
      tests++; if (q_out !== 16'd0 || q_count !== 4'd0 || q_ovf !== 1'b0) begin
         fails++; $display("FAIL mid_reset_q: got out=%0d count=%0d ovf=%0b expected 0/0/0", q_out, q_count, q_ovf); end
      tests++; if (l_out !== 16'd0) begin fails++; $display("FAIL mid_reset_live: got %0d expected 0", l_out); end
      q_rd = 1'b1; tick(); idle_inputs();
      tests++; if (q_out !== 16'd0 || q_count !== 4'd0) begin
         fails++; $display("FAIL mid_reset_after: got out=%0d count=%0d expected 0/0", q_out, q_count); end
   endtask

   task automatic test_random();
      logic [15:0] codes [4];
      logic [15:0] exp_q;
      codes[0] = 16'd0; codes[1] = 16'd65; codes[2] = 16'd66; codes[3] = 16'd67;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rst_n     = ($urandom_range(0, 79) != 0);
         l_valid   = $urandom_range(0, 1);
         l_release = $urandom_range(0, 1);
         l_code    = codes[$urandom_range(0, 3)];
         l_rd      = $urandom_range(0, 1);
         l_clr     = $urandom_range(0, 1);
         q_valid   = ($urandom_range(0, 3) != 0);
         q_release = ($urandom_range(0, 4) == 0);
         q_code    = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         q_rd      = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
         q_clr     = ($urandom_range(0, 15) == 0);
         tests++; if (q_ready !== (qm.size() != 8)) begin
            fails++; $display("FAIL rnd_q_ready: got %0b expected %0b", q_ready, qm.size() != 8); end
         tick();
         exp_q = (qm.size() > 0) ? qm[0] : 16'd0;
         tests++; if (q_out !== exp_q || q_count !== 4'(qm.size()) || q_ovf !== qm_ovf) begin
            fails++; $display("FAIL rnd_q: got out=%0d count=%0d ovf=%0b expected %0d/%0d/%0b",
                              q_out, q_count, q_ovf, exp_q, qm.size(), qm_ovf); end
         tests++; if (l_out !== (lm_on ? lm_held : 16'd0) || l_count !== 4'd0 || l_ovf !== 1'b0 || l_ready !== 1'b1) begin
            fails++; $display("FAIL rnd_live: got out=%0d count=%0d ovf=%0b ready=%0b expected %0d/0/0/1",
                              l_out, l_count, l_ovf, l_ready, lm_on ? lm_held : 16'd0); end
      end
      rst_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      qm_ovf = 1'b0; lm_on = 1'b0; lm_held = 16'd0;
      tick();
      test_reset();
      test_live();
      test_queued();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keyboard_buffer.md
KEYBOARD_BUFFER -- requirements
Module: keyboard_buffer

Interface
REQ-001 Parameter WIDTH, default 16, key-code and output width in bits.
REQ-002 Parameter DEPTH, default 8, FIFO depth in entries; power of two, at least 2.
REQ-003 Parameter BUFFERED, default 0; 0 selects live (held-key) mode, 1 selects queued mode.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 key_valid  input  1  key event present this cycle.
REQ-007 key_ready  output  1  block accepts the event this cycle.
REQ-008 key_code  input  WIDTH  key code of the event.
REQ-009 key_release  input  1  1 = release event, 0 = press event.
REQ-010 rd_en  input  1  CPU consumes the current out value (queued mode only).
REQ-011 clr_ovf  input  1  clears the overflow flag.
REQ-012 out  output  WIDTH  keyboard memory-map word; 0 = no key.
REQ-013 count  output  $clog2(DEPTH)+1  entries queued; always 0 in live mode.
REQ-014 overflow  output  1  sticky flag: a press was dropped.

Function
REQ-015 An event SHALL be accepted on a rising edge where key_valid and key_ready are both 1.
REQ-016 A press with key_code == 0 SHALL be accepted and discarded, with no state change.
REQ-017 In live mode, key_ready SHALL be constantly 1, and state SHALL be an FSM with states IDLE and HELD plus a WIDTH-bit held register.
REQ-018 In live mode, a press SHALL load held with key_code and enter HELD, from either state; a newer press replaces the held key.
REQ-019 In live mode, a release whose code equals held SHALL return the FSM to IDLE; any other release SHALL be ignored.
REQ-020 In live mode, out SHALL equal held in HELD and 0 in IDLE, visible in the cycle after the accepting edge.
REQ-021 In queued mode, key_ready SHALL equal (count != DEPTH), and every release event SHALL be accepted and discarded.
REQ-022 In queued mode, an accepted nonzero press SHALL be written at the write pointer, and count SHALL increment.
REQ-023 In queued mode, out SHALL equal the head entry when count > 0 and 0 when count == 0, driven only from registers.
REQ-024 In queued mode, rd_en with count > 0 SHALL advance the read pointer and decrement count; rd_en with count == 0 SHALL be ignored.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and advance both pointers; when count == DEPTH, the pop frees the slot but key_ready stays 0 that cycle.
REQ-026 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 overflow SHALL set on an edge where key_valid == 1, key_ready == 0, key_release == 0 and key_code != 0.
REQ-028 overflow SHALL clear on an edge with clr_ovf == 1 unless set on the same edge; set wins.
REQ-029 In live mode, overflow SHALL remain 0 and rd_en SHALL have no effect.

Reset
REQ-030 On a rising edge with rst_n == 0: FSM = IDLE, held = 0, pointers = 0, count = 0, overflow = 0, out = 0; events, rd_en and clr_ovf that cycle SHALL be ignored.
REQ-031 Reset mid-operation SHALL discard all queued codes, with no partial state retained.
REQ-032 FIFO storage contents need not be reset; out SHALL still read 0 while count == 0.

Verification
REQ-033 Live: press 65, later release 65 -> out = 65 from the cycle after the press until the cycle after the release, then 0.
REQ-034 Live: press 65, press 66, release 65 -> out stays 66; release 66 -> out = 0.
REQ-035 Queued, DEPTH = 8: push 65, 66, 67, no reads -> count = 3, out = 65; rd_en once -> out = 66, count = 2.
REQ-036 Queued: push 9 codes with no reads -> 9th dropped, key_ready = 0 while count == 8, overflow = 1; clr_ovf -> overflow = 0; 8 reads return codes 1..8 in order across the pointer wrap.
REQ-037 Queued: count == 1 with push 70 and rd_en on the same edge -> count = 1, out = 70; rd_en at count == 0 -> no change.
REQ-038 Either mode: rst_n low for one edge with 4 entries queued or a key held -> out = 0, count = 0, overflow = 0 on the next cycle.
